intensity_shade: RTL and testbench
==================================

INTENSITY_SHADE -- requirements
Module: intensity_shade

Interface
REQ-001 SHALL have parameter NORM_WIDTH, default 16, giving the signed intensity width.
REQ-002 SHALL have parameter NORM_FRAC, default 14, giving the number of intensity fraction bits; 1.0 = 2^NORM_FRAC.
REQ-003 SHALL have parameter AMBIENT, default 16'h0666 (~0.1), giving the minimum effective intensity, unsigned, same format.
REQ-004 SHALL have parameter TAG_WIDTH, default 16, giving the triangle id width.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, a power of 2, giving the output buffer depth.
REQ-006 SHALL have port clk_in, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst_in, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port tri_valid_in, input, 1 bit: a triangle beat is present this cycle.
REQ-009 SHALL have port facing_in, input, 1 bit: front-facing flag from the lighting stage; 0 means culled.
REQ-010 SHALL have port intensity_in, input, NORM_WIDTH bits, signed: light intensity.
REQ-011 SHALL have port base_color_in, input, 16 bits: RGB565 base colour.
REQ-012 SHALL have port tri_id_in, input, TAG_WIDTH bits: triangle tag.
REQ-013 SHALL have port color_out, output, 16 bits: shaded RGB565 at the FIFO head.
REQ-014 SHALL have port tri_id_out, output, TAG_WIDTH bits: tag at the FIFO head.
REQ-015 SHALL have port valid_out, output, 1 bit: FIFO is non-empty.
REQ-016 SHALL have port ready_in, input, 1 bit: downstream accepts the head entry this cycle.
REQ-017 SHALL have port overflow_out, output, 1 bit: sticky flag for a dropped result.
REQ-018 SHALL have port shaded_count_out, output, 16 bits: count of front-facing beats accepted.
REQ-019 SHALL have port culled_count_out, output, 16 bits: count of culled beats accepted.

Function
REQ-020 Input SHALL never stall; no ready is exported upstream.
REQ-021 A beat SHALL be accepted every cycle that tri_valid_in=1.
REQ-022 An accepted beat with facing_in=0 SHALL increment culled_count_out, produce no output, and leave the FIFO unchanged.
REQ-023 An accepted beat with facing_in=1 SHALL increment shaded_count_out and enter the 2-stage shading pipeline.
REQ-024 Both counters SHALL wrap modulo 2^16.
REQ-025 Stage 1 SHALL register the clamped, floored intensity:
- negative intensity becomes 0;
- intensity above 2^NORM_FRAC becomes 2^NORM_FRAC;
- the result is then max(result, AMBIENT).
REQ-026 Stage 1 SHALL also register base_color_in and tri_id_in.
REQ-027 Stage 2 SHALL compute each channel (R5, G6, B5) as floor(channel*eff >> NORM_FRAC) using unsigned products wide enough to avoid loss.
REQ-028 A stage-2 result can never exceed the channel max; no saturation logic SHALL be needed.
REQ-029 A beat accepted at edge k SHALL be written to the FIFO at edge k+2.
REQ-030 If the FIFO was empty, valid_out SHALL be 1 in the cycle after edge k+2 (latency 2).
REQ-031 The FIFO SHALL be first-word-fall-through: color_out and tri_id_out show the head entry whenever valid_out=1, and hold their values while ready_in=0.
REQ-032 A pop SHALL occur on a cycle with valid_out=1 and ready_in=1.
REQ-033 ready_in while empty SHALL be ignored.
REQ-034 Push and pop in the same cycle SHALL be allowed at any occupancy, including full; occupancy is then unchanged.
REQ-035 A push when full and not popping SHALL drop the new result, keep existing entries, and set overflow_out=1 until reset.
REQ-036 Output order SHALL equal input acceptance order.

Reset
REQ-037 While rst_in=1 at an edge, the block SHALL clear:
- the pipeline valids;
- the FIFO pointers and occupancy;
- the FIFO storage (so color_out=0 and tri_id_out=0);
- valid_out=0;
- overflow_out=0;
- both counters to 0.
REQ-038 Reset mid-operation SHALL discard all in-flight and buffered beats.
REQ-039 Beats presented during reset SHALL not be counted.
REQ-040 A beat presented on the first cycle after reset deasserts SHALL be accepted normally.

Verification
REQ-041 Full and half intensity, ready_in=1:
- base 16'hFFFF, intensity 16'h4000 -> color_out=16'hFFFF, 2 cycles later;
- intensity 16'h2000 -> 16'h7BEF.
REQ-042 Clamp and floor:
- intensity 16'h5000 on base 16'hFFFF -> 16'hFFFF;
- intensity 16'hC000 (negative) -> ambient floor, 16'h18C3.
REQ-043 Culling: three beats with facing_in = 1, 0, 1 -> two outputs in order, shaded_count_out=2, culled_count_out=1.
REQ-044 Backpressure and overflow: ready_in=0 with 6 consecutive front-facing beats (ids 0..5) -> 4 entries held, overflow_out=1; ready_in=1 then drains ids 0..3 and valid_out drops.
REQ-045 Full and simultaneous: FIFO full with push and pop in the same cycle -> no overflow, occupancy stays 4, order preserved.
REQ-046 Reset mid-stream: assert rst_in with 2 beats in flight and 3 buffered -> the next cycle shows valid_out=0, counters=0, overflow_out=0, and no stale output ever appears afterwards.

Source files
------------

// File: rtl/intensity_shade.sv
// intensity_shade: culls back faces, scales RGB565 by clamped light intensity, buffers results in a FWFT FIFO
module intensity_shade #(
  parameter int NORM_WIDTH = 16,
  parameter int NORM_FRAC = 14,
  parameter logic [NORM_WIDTH-1:0] AMBIENT = 16'h0666,
  parameter int TAG_WIDTH = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  tri_valid_in,
  input  logic                  facing_in,
  input  logic [NORM_WIDTH-1:0] intensity_in,
  input  logic [15:0]           base_color_in,
  input  logic [TAG_WIDTH-1:0]  tri_id_in,
  output logic [15:0]           color_out,
  output logic [TAG_WIDTH-1:0]  tri_id_out,
  output logic                  valid_out,
  input  logic                  ready_in,
  output logic                  overflow_out,
  output logic [15:0]           shaded_count_out,
  output logic [15:0]           culled_count_out
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = NORM_WIDTH + 6;
  localparam logic [NORM_WIDTH-1:0] ONE = NORM_WIDTH'(1) << NORM_FRAC;
  logic [NORM_WIDTH-1:0] clamped, eff, s1_eff;
  logic                  s1_valid, s2_valid;
  logic [15:0]           s1_color, s2_color, shaded;
  logic [TAG_WIDTH-1:0]  s1_id, s2_id;
  logic [PW-1:0]         pr, pg, pb;
  logic [15:0]           mem_color [FIFO_DEPTH];
  logic [TAG_WIDTH-1:0]  mem_id [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [AW:0]           count;
  logic                  full, pop, push_ok;
  always_comb begin
    clamped = intensity_in[NORM_WIDTH-1] ? '0 : (intensity_in > ONE ? ONE : intensity_in);
    eff = clamped < AMBIENT ? AMBIENT : clamped;
    pr = PW'(s1_color[15:11]) * PW'(s1_eff);
    pg = PW'(s1_color[10:5]) * PW'(s1_eff);
    pb = PW'(s1_color[4:0]) * PW'(s1_eff);
    shaded = {5'(pr >> NORM_FRAC), 6'(pg >> NORM_FRAC), 5'(pb >> NORM_FRAC)};
  end
  assign valid_out = count != '0;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign pop = valid_out & ready_in;
  // a full FIFO still accepts a push when the head leaves in the same cycle
  assign push_ok = s2_valid & (~full | pop);
  assign color_out = mem_color[rd_ptr];
  assign tri_id_out = mem_id[rd_ptr];
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow_out <= 1'b0;
      shaded_count_out <= '0;
      culled_count_out <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_color[i] <= '0;
        mem_id[i] <= '0;
      end
    end else begin
      s1_valid <= tri_valid_in & facing_in;
      s1_eff <= eff;
      s1_color <= base_color_in;
      s1_id <= tri_id_in;
      s2_valid <= s1_valid;
      s2_color <= shaded;
      s2_id <= s1_id;
      if (push_ok) begin
        mem_color[wr_ptr] <= s2_color;
        mem_id[wr_ptr] <= s2_id;
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(push_ok) - (AW+1)'(pop);
      if (s2_valid & full & ~pop) overflow_out <= 1'b1;
      if (tri_valid_in & facing_in) shaded_count_out <= shaded_count_out + 16'd1;
      if (tri_valid_in & ~facing_in) culled_count_out <= culled_count_out + 16'd1;
    end
  end
endmodule

// File: tb/tb_intensity_shade.sv
// tb_intensity_shade: directed and random beats checked against a scoreboard of modelled shaded colours
module tb_intensity_shade;
  logic clk_in = 0, rst_in = 1, tri_valid_in = 0, facing_in = 0, ready_in = 0;
  logic [15:0] intensity_in = 0, base_color_in = 0, tri_id_in = 0;
  logic [15:0] color_out, tri_id_out, shaded_count_out, culled_count_out;
  logic valid_out, overflow_out;
  int n_chk = 0, n_pass = 0;
  logic [31:0] q[$];
  logic [15:0] exp_sh = 0, exp_cu = 0;
  always #5 clk_in = ~clk_in;
  intensity_shade dut (
    .clk_in(clk_in), .rst_in(rst_in), .tri_valid_in(tri_valid_in), .facing_in(facing_in),
    .intensity_in(intensity_in), .base_color_in(base_color_in), .tri_id_in(tri_id_in),
    .color_out(color_out), .tri_id_out(tri_id_out), .valid_out(valid_out), .ready_in(ready_in),
    .overflow_out(overflow_out), .shaded_count_out(shaded_count_out), .culled_count_out(culled_count_out)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask
  function automatic logic [15:0] shade(input logic [15:0] c, input logic [15:0] i);
    int e, r, g, b;
    e = int'($signed(i));
    e = e < 0 ? 0 : (e > 16384 ? 16384 : e);
    if (e < 1638) e = 1638;
    r = (int'(c[15:11]) * e) >> 14;
    g = (int'(c[10:5]) * e) >> 14;
    b = (int'(c[4:0]) * e) >> 14;
    return {r[4:0], g[5:0], b[4:0]};
  endfunction
  always @(negedge clk_in) begin : mon
    logic [31:0] e;
    if (!rst_in && valid_out) begin
      if (q.size() == 0) e = 'x;
      else if (ready_in) e = q.pop_front();
      else e = q[0];
      chk("head", {tri_id_out, color_out}, e);
    end
  end
  task automatic beat(input logic f, input logic [15:0] i, input logic [15:0] c, input logic [15:0] id, input logic keep = 1'b1);
    tri_valid_in = 1; facing_in = f; intensity_in = i; base_color_in = c; tri_id_in = id;
    if (f) begin
      exp_sh++;
      if (keep) q.push_back({id, shade(c, i)});
    end else exp_cu++;
    @(posedge clk_in);
    #1 tri_valid_in = 0;
  endtask
  task automatic drain();
    ready_in = 1;
    for (int k = 0; k < 40 && q.size() != 0; k++) @(posedge clk_in);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("drained", q.size(), 0);
    chk("valid_low", valid_out, 0);
  endtask
  task automatic do_reset();
    rst_in = 1; q.delete(); exp_sh = 0; exp_cu = 0;
    repeat (2) @(posedge clk_in);
    #1 rst_in = 0;
  endtask
  task automatic chk_counts();
    chk("shaded_cnt", shaded_count_out, exp_sh);
    chk("culled_cnt", culled_count_out, exp_cu);
  endtask
  initial begin
    tri_valid_in = 1; facing_in = 1; intensity_in = 16'h4000; base_color_in = 16'hFFFF;
    repeat (3) @(posedge clk_in);
    #1 tri_valid_in = 0; rst_in = 0;
    @(negedge clk_in);
    chk("rst_valid", valid_out, 0);
    chk("rst_color", color_out, 0);
    chk("rst_id", tri_id_out, 0);
    chk("rst_ovf", overflow_out, 0);
    chk_counts();
    ready_in = 1;
    beat(1, 16'h4000, 16'hFFFF, 1);
    @(negedge clk_in);
    @(negedge clk_in);
    chk("latency_early", valid_out, 0);
    @(negedge clk_in);
    chk("latency_on", valid_out, 1);
    chk("full_white", color_out, 16'hFFFF);
    beat(1, 16'h2000, 16'hFFFF, 2);
    beat(1, 16'h5000, 16'hFFFF, 3);
    beat(1, 16'hC000, 16'hFFFF, 4);
    beat(1, 16'h3000, 16'hA5C3, 5);
    beat(1, 16'h7FFF, 16'h1234, 6);
    beat(1, 16'h8000, 16'hFFFF, 7);
    beat(1, 16'h0666, 16'hFFFF, 8);
    beat(1, 16'h4001, 16'h8410, 9);
    drain();
    chk_counts();
    for (int k = 0; k < 12; k++)
      beat(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 16'(100 + k));
    drain();
    chk_counts();
    do_reset();
    ready_in = 1;
    beat(1, 16'h4000, 16'hF800, 30);
    beat(0, 16'h4000, 16'h07E0, 31);
    beat(1, 16'h2000, 16'h001F, 32);
    drain();
    chk("cull_shaded", shaded_count_out, 2);
    chk("cull_culled", culled_count_out, 1);
    do_reset();
    ready_in = 0;
    for (int k = 0; k < 6; k++) beat(1, 16'(16'h4000 - k * 16'h0800), 16'(16'hFFFF - k), 16'(k), k < 4);
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    chk("ovf_set", overflow_out, 1);
    chk("ovf_valid", valid_out, 1);
    chk("ovf_head_id", tri_id_out, 0);
    drain();
    chk("ovf_sticky", overflow_out, 1);
    chk_counts();
    do_reset();
    ready_in = 0;
    for (int k = 0; k < 4; k++) beat(1, 16'h3000, 16'(16'h1111 * (k + 1)), 16'(10 + k));
    beat(1, 16'h2000, 16'hFFFF, 14);
    @(posedge clk_in);
    #1 ready_in = 1;
    @(posedge clk_in);
    #1 ready_in = 0;
    @(negedge clk_in);
    chk("simul_no_ovf", overflow_out, 0);
    chk("simul_head", tri_id_out, 11);
    drain();
    do_reset();
    ready_in = 0;
    beat(1, 16'h4000, 16'hAAAA, 20);
    beat(1, 16'h2000, 16'hBBBB, 21);
    beat(1, 16'h1000, 16'hCCCC, 22);
    repeat (3) @(posedge clk_in);
    #1;
    beat(1, 16'h4000, 16'hDDDD, 23);
    beat(1, 16'h4000, 16'hEEEE, 24);
    rst_in = 1; q.delete(); exp_sh = 0; exp_cu = 0;
    @(posedge clk_in);
    #1 rst_in = 0;
    @(negedge clk_in);
    chk("mid_valid", valid_out, 0);
    chk("mid_ovf", overflow_out, 0);
    chk("mid_color", color_out, 0);
    chk("mid_id", tri_id_out, 0);
    chk_counts();
    ready_in = 1;
    beat(1, 16'h4000, 16'h07E0, 40);
    repeat (10) @(negedge clk_in);
    drain();
    chk_counts();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
